xif_coproc_router: RTL



---
 rtl/xif_coproc_router_if.sv | 69 ++++++
 rtl/xif_coproc_router.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_router_if.sv
// X-IF bundle between the core bridge, the router and the coprocessors.
// The slave modport is the router's view; master is the surrounding system.
interface xif_coproc_router_if #(
  parameter int NUM_COPROC = 2,
  parameter int ID_WIDTH   = 4,
  parameter int XLEN       = 32,
  parameter int NUM_RS     = 2
);
  // core issue
  logic                           issue_valid_i, issue_ready_o;
  logic [31:0]                    issue_instr_i;
  logic [ID_WIDTH-1:0]            issue_id_i;
  logic [NUM_RS-1:0][XLEN-1:0]    issue_rs_i;
  logic [NUM_RS-1:0]              issue_rs_valid_i;
  logic                           issue_accept_o, issue_writeback_o;
  // core commit
  logic                           commit_valid_i;
  logic [ID_WIDTH-1:0]            commit_id_i;
  logic                           commit_kill_i;
  // core result
  logic                           result_valid_o, result_ready_i;
  logic [ID_WIDTH-1:0]            result_id_o;
  logic [XLEN-1:0]                result_data_o;
  logic [4:0]                     result_rd_o;
  logic                           result_we_o;
  // coprocessor issue
  logic [NUM_COPROC-1:0]          cp_issue_valid_o;
  logic [31:0]                    cp_issue_instr_o;
  logic [ID_WIDTH-1:0]            cp_issue_id_o;
  logic [NUM_RS-1:0][XLEN-1:0]    cp_issue_rs_o;
  logic [NUM_RS-1:0]              cp_issue_rs_valid_o;
  logic [NUM_COPROC-1:0]          cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i;
  // coprocessor commit
  logic [NUM_COPROC-1:0]          cp_commit_valid_o;
  logic [ID_WIDTH-1:0]            cp_commit_id_o;
  logic                           cp_commit_kill_o;
  // coprocessor result
  logic [NUM_COPROC-1:0]          cp_result_valid_i, cp_result_ready_o;
  logic [NUM_COPROC-1:0][ID_WIDTH-1:0] cp_result_id_i;
  logic [NUM_COPROC-1:0][XLEN-1:0]     cp_result_data_i;
  logic [NUM_COPROC-1:0][4:0]          cp_result_rd_i;
  logic [NUM_COPROC-1:0]          cp_result_we_i;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    input  result_ready_i,
    output cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o,
    input  cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    output cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
    input  cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_rd_i, cp_result_we_i,
    output cp_result_ready_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    output result_ready_i,
    input  cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o,
    output cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    input  cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
    output cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_rd_i, cp_result_we_i,
    input  cp_result_ready_o
  );
endinterface

// File: rtl/xif_coproc_router.sv
// One core to NUM_COPROC coprocessors X-IF router: priority issue probe,
// per-ID owner table for commit steering, round-robin result merge via FIFO.
module xif_coproc_router #(
  parameter int NUM_COPROC     = 2,
  parameter int ID_WIDTH       = 4,
  parameter int XLEN           = 32,
  parameter int NUM_RS         = 2,
  parameter int RES_FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  xif_coproc_router_if.slave  bus,
  output logic [ID_WIDTH:0]   outstanding_o,
  output logic                err_o
);
  localparam int PW  = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;
  localparam int NID = 1 << ID_WIDTH;
  localparam int AW  = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(RES_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     data;
    logic [4:0]          rd;
    logic                we;
  } res_t;

  logic [PW-1:0]           probe_idx, probe_nxt, rr, grant_idx;
  logic                    issue_hs, accept_hs, err_probe, err_acc, err_cm, err_res;
  logic                    cm_hit, grant_any, push, pop, fifo_full, fifo_empty;
  logic [NID-1:0]          valid_q, valid_d;
  logic [NID-1:0][PW-1:0]  owner_q, owner_d;
  logic [ID_WIDTH:0]       pop_cnt;
  res_t                    fifo_q [RES_FIFO_DEPTH];
  res_t                    res_in, head;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  // Issue probe: offer to probe_idx, advance on reject, finish on accept or last reject.
  always_comb begin
    probe_nxt = probe_idx;
    issue_hs  = 1'b0;
    accept_hs = 1'b0;
    err_probe = 1'b0;
    if (!bus.issue_valid_i) begin
      probe_nxt = '0;
      err_probe = (probe_idx != '0);
    end else if (bus.cp_issue_ready_i[probe_idx]) begin
      if (bus.cp_issue_accept_i[probe_idx]) begin
        issue_hs  = 1'b1;
        accept_hs = 1'b1;
        probe_nxt = '0;
      end else if (probe_idx == PW'(NUM_COPROC - 1)) begin
        issue_hs  = 1'b1;
        probe_nxt = '0;
      end else begin
        probe_nxt = probe_idx + 1'b1;
      end
    end
  end

  // Core/coprocessor outputs; everything is forced low while reset is asserted.
  always_comb begin
    bus.cp_issue_valid_o            = '0;
    bus.cp_issue_valid_o[probe_idx] = bus.issue_valid_i & rst_ni;
    bus.issue_ready_o       = issue_hs & rst_ni;
    bus.issue_accept_o      = accept_hs & rst_ni;
    bus.issue_writeback_o   = accept_hs & bus.cp_issue_writeback_i[probe_idx] & rst_ni;
    bus.cp_issue_instr_o    = rst_ni ? bus.issue_instr_i    : '0;
    bus.cp_issue_id_o       = rst_ni ? bus.issue_id_i       : '0;
    bus.cp_issue_rs_o       = rst_ni ? bus.issue_rs_i       : '0;
    bus.cp_issue_rs_valid_o = rst_ni ? bus.issue_rs_valid_i : '0;
    cm_hit                  = bus.commit_valid_i & valid_q[bus.commit_id_i];
    err_cm                  = bus.commit_valid_i & ~valid_q[bus.commit_id_i];
    bus.cp_commit_valid_o   = '0;
    bus.cp_commit_valid_o[owner_q[bus.commit_id_i]] = cm_hit & rst_ni;
    bus.cp_commit_id_o      = rst_ni ? bus.commit_id_i : '0;
    bus.cp_commit_kill_o    = bus.commit_kill_i & rst_ni;
  end

  // Round-robin result arbiter: first requester at or after rr.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = rr;
    for (int i = 0; i < NUM_COPROC; i++) begin
      idx = (int'(rr) + i) % NUM_COPROC;
      if (!grant_any && bus.cp_result_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    push                  = grant_any & ~fifo_full;
    pop                   = ~fifo_empty & bus.result_ready_i;
    bus.cp_result_ready_o = '0;
    bus.cp_result_ready_o[grant_idx] = push & rst_ni;
    res_in.id   = bus.cp_result_id_i[grant_idx];
    res_in.data = bus.cp_result_data_i[grant_idx];
    res_in.rd   = bus.cp_result_rd_i[grant_idx];
    res_in.we   = bus.cp_result_we_i[grant_idx];
    err_res     = push & (~valid_q[res_in.id] | (owner_q[res_in.id] != grant_idx));
  end

  // Owner table next state: clears first, a same-cycle accept wins.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    err_acc = accept_hs & valid_q[bus.issue_id_i];
    if (cm_hit && bus.commit_kill_i) valid_d[bus.commit_id_i] = 1'b0;
    if (push)                        valid_d[res_in.id]       = 1'b0;
    if (accept_hs) begin
      valid_d[bus.issue_id_i] = 1'b1;
      owner_d[bus.issue_id_i] = probe_idx;
    end
    pop_cnt = '0;
    for (int i = 0; i < NID; i++) pop_cnt = pop_cnt + {{ID_WIDTH{1'b0}}, valid_d[i]};
  end

  // Control state: probe index, arbiter pointer, table, count and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      probe_idx     <= '0;
      rr            <= '0;
      valid_q       <= '0;
      owner_q       <= '0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      probe_idx     <= probe_nxt;
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      outstanding_o <= pop_cnt;
      err_o         <= err_o | err_probe | err_acc | err_cm | err_res;
      if (push) rr  <= (grant_idx == PW'(NUM_COPROC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(RES_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(RES_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result FIFO storage; contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= res_in;
  end

  assign fifo_full          = (count == CW'(RES_FIFO_DEPTH));
  assign fifo_empty         = (count == '0);
  assign head               = fifo_empty ? '0 : fifo_q[rd_ptr];
  assign bus.result_valid_o = ~fifo_empty;
  assign bus.result_id_o    = head.id;
  assign bus.result_data_o  = head.data;
  assign bus.result_rd_o    = head.rd;
  assign bus.result_we_o    = head.we;
endmodule
